seq_divider: RTL and testbench



---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 29 ++
 rtl/seq_divider.sv | 104 ++++++++++
 tb/tb_seq_divider.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   DEF_W     : default divisor/remainder width (dividend/quotient are 2*W)
//   state_t   : FSM encoding IDLE/RUN/DONE (2 bits)
//   cnt_width : iteration counter width for a given W, i.e. $clog2(2*W)
package div_pkg;
  localparam int DEF_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (2 * w > 1) ? $clog2(2 * w) : 1;
  endfunction
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration (combinational).
//   pr      : current partial remainder (W+1 bits)
//   din     : next dividend bit, shifted in at the LSB
//   d       : divisor
//   pr_next : partial remainder after the trial subtract / restore
//   qbit    : quotient bit produced by this iteration
module div_step
  import div_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W:0]   pr,
  input  logic         din,
  input  logic [W-1:0] d,
  output logic [W:0]   pr_next,
  output logic         qbit
);
  logic [W+1:0] shifted;
  logic [W+1:0] trial;

  // One extra bit of headroom so the borrow of the trial subtract shows
  // up as the sign bit; the shifted value always fits in W+1 bits.
  always_comb begin
    shifted = {pr, din};
    trial   = shifted - {2'b00, d};
    qbit    = ~trial[W+1];
    pr_next = qbit ? trial[W:0] : shifted[W:0];
  end
endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// 2W-bit dividend / W-bit divisor -> 2W-bit quotient, W-bit remainder.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : request, sampled only in IDLE or DONE
//   dividend  : numerator, captured on accept
//   divisor   : denominator, captured on accept
//   busy      : high while iterating (RUN)
//   done      : one-cycle pulse, results valid
//   quotient  : result, held until next accept
//   remainder : result, held until next accept
//   div0      : captured divisor was zero (quotient all ones)
module seq_divider
  import div_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] quotient,
  output logic [W-1:0]   remainder,
  output logic           div0
);
  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(2 * W - 1);

  state_t         state;
  logic [W-1:0]   dvs;  // latched divisor
  logic [W:0]     pr;   // partial remainder
  logic [2*W-1:0] sq;   // dividend shifts out MSB-first, quotient shifts in
  logic [CW-1:0]  cnt;
  logic [W:0]     pr_next;
  logic           qbit;

  div_step #(.W(W)) u_step (
    .pr      (pr),
    .din     (sq[2*W-1]),
    .d       (dvs),
    .pr_next (pr_next),
    .qbit    (qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      div0  <= 1'b0;
      dvs   <= '0;
      pr    <= '0;
      sq    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            dvs <= divisor;
            cnt <= '0;
            if (divisor == '0) begin
              // Divide by zero skips iteration and reports immediately.
              state <= ST_DONE;
              done  <= 1'b1;
              div0  <= 1'b1;
              sq    <= '1;
              pr    <= {1'b0, dividend[W-1:0]};
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
              div0  <= 1'b0;
              sq    <= dividend;
              pr    <= '0;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sq  <= {sq[2*W-2:0], qbit};
          pr  <= pr_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient  = sq;
  assign remainder = pr[W-1:0];
endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [2*W-1:0] dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic           busy, done, div0;
  logic [2*W-1:0] quotient;
  logic [W-1:0]   remainder;

  int tests = 0;
  int fails = 0;

  seq_divider #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  task automatic model(input logic [2*W-1:0] a, input logic [W-1:0] b,
                       output logic [2*W-1:0] q, output logic [W-1:0] r);
    if (b == 0) begin
      q = '1;
      r = a[W-1:0];
    end else begin
      q = a / {{W{1'b0}}, b};
      r = W'(a % {{W{1'b0}}, b});
    end
  endtask

  // Called at posedge+1 with the DUT in IDLE or DONE; returns at the
  // sample where done is seen (so a following call is back-to-back).
  task automatic run_op(input string tag, input logic [2*W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] eq;
    logic [W-1:0]   er;
    int lat, bcnt, elat;
    model(a, b, eq, er);
    elat = (b == 0) ? 0 : 2 * W;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_acc_done"}, 32'(done), (b == 0) ? 1 : 0);
    check({tag, "_acc_busy"}, 32'(busy), (b == 0) ? 0 : 1);
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, elat);
    check({tag, "_busycyc"}, bcnt, elat);
    check({tag, "_q"}, 32'(quotient), 32'(eq));
    check({tag, "_r"}, 32'(remainder), 32'(er));
    check({tag, "_div0"}, 32'(div0), (b == 0) ? 1 : 0);
  endtask

  initial begin
    int seen;
    logic [2*W-1:0] ra;
    logic [W-1:0]   rb;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_q", 32'(quotient), 0);
    check("rst_r", 32'(remainder), 0);
    check("rst_div0", 32'(div0), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed operands
    run_op("basic", 16'd1000, 8'd7);
    @(posedge clk); #1;
    check("hold_done", 32'(done), 0);
    check("hold_q", 32'(quotient), 142);
    check("hold_r", 32'(remainder), 6);
    run_op("max255", 16'd65535, 8'd255);
    run_op("max1", 16'd65535, 8'd1);
    @(posedge clk); #1;
    run_op("small", 16'd100, 8'd200);
    @(posedge clk); #1;
    run_op("dz", 16'h1234, 8'd0);
    @(posedge clk); #1;
    check("dz_hold_div0", 32'(div0), 1);
    run_op("after_dz", 16'd10, 8'd3);
    @(posedge clk); #1;

    // start pulsed during RUN is ignored
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; dividend = 16'd50; divisor = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    while (!done && seen < 100) begin @(posedge clk); #1; seen++; end
    check("ign_latency", seen, 2 * W - 4);
    check("ign_q", 32'(quotient), 142);
    check("ign_r", 32'(remainder), 6);

    // Back-to-back: start held in the DONE cycle
    @(posedge clk); #1;
    run_op("b2b_first", 16'd1000, 8'd7);
    run_op("b2b_second", 16'd50, 8'd5);
    @(posedge clk); #1;

    // Reset during iteration 8
    start = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_done", 32'(done), 0);
    check("mrst_q", 32'(quotient), 0);
    check("mrst_r", 32'(remainder), 0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (done) seen++; end
    check("mrst_no_done", seen, 0);
    run_op("post_rst", 16'd1000, 8'd7);
    @(posedge clk); #1;

    // Randomized operands against the reference model
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 5) == 0) rb = '0;
      else if ($urandom_range(0, 3) == 0) rb = 8'($urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) ra = 16'($urandom_range(0, 300));
      run_op("rand", ra, rb);
      if ($urandom_range(0, 1) == 0) begin @(posedge clk); #1; end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
